// File: rtl/morse_text_buffer.sv
// Line buffer for decoded Morse letters: synchronizes send/backspace buttons, appends
// committed letter codes, and exposes a registered column-addressed read port.
module morse_text_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          send,
  input  logic          bksp,
  input  logic          clear,
  input  logic [CW-1:0] letter_num,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic          commit
);

  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_VALID = CW'(27);

  // Edge-detect state per button
  localparam logic IDLE  = 1'b0;
  localparam logic ARMED = 1'b1;

  logic send_meta_q, send_sync_q, send_state_q, send_rdy_q;
  logic bksp_meta_q, bksp_sync_q, bksp_state_q, bksp_rdy_q;
  logic [1:0] prime_q;

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] rd_data_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          commit_q;

  logic          send_req, bksp_req;
  logic          letter_valid;
  logic          do_bksp, do_send, set_ovf;
  logic [AW:0]   count_m1;
  logic [AW-1:0] wr_idx, bk_idx;

  // Synchronizers and edge-detect flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send_meta_q  <= 1'b0;
      send_sync_q  <= 1'b0;
      send_state_q <= IDLE;
      bksp_meta_q  <= 1'b0;
      bksp_sync_q  <= 1'b0;
      bksp_state_q <= IDLE;
    end else begin
      send_meta_q  <= send;
      send_sync_q  <= send_meta_q;
      send_state_q <= send_sync_q ? ARMED : IDLE;
      bksp_meta_q  <= bksp;
      bksp_sync_q  <= bksp_meta_q;
      bksp_state_q <= bksp_sync_q ? ARMED : IDLE;
    end
  end

  // A button held through reset release must be seen low before it can request again.
  // prime_q reaches 2 once the sync stage holds a real sample taken after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q    <= 2'd0;
      send_rdy_q <= 1'b0;
      bksp_rdy_q <= 1'b0;
    end else begin
      if (prime_q != 2'd2) begin
        prime_q <= prime_q + 2'd1;
      end
      if ((prime_q == 2'd2) && !send_sync_q) begin
        send_rdy_q <= 1'b1;
      end
      if ((prime_q == 2'd2) && !bksp_sync_q) begin
        bksp_rdy_q <= 1'b1;
      end
    end
  end

  always_comb begin
    send_req     = send_rdy_q && send_sync_q && (send_state_q == IDLE);
    bksp_req     = bksp_rdy_q && bksp_sync_q && (bksp_state_q == IDLE);
    letter_valid = (letter_num != '0) && (letter_num <= LAST_VALID);
    full         = (count_q == DEPTH_CNT);

    // clear > backspace > send; a losing request is simply dropped
    do_bksp  = !clear && bksp_req && (count_q != '0);
    do_send  = !clear && !bksp_req && send_req && letter_valid && !full;
    set_ovf  = !clear && !bksp_req && send_req && letter_valid && full;

    count_m1 = count_q - 1'b1;
    wr_idx   = count_q[AW-1:0];
    bk_idx   = count_m1[AW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_bksp) begin
      mem_q[bk_idx] <= '0;
    end else if (do_send) begin
      mem_q[wr_idx] <= letter_num;
    end
  end

  // Non-blocking read gives read-before-write for a same-cycle update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      commit_q <= do_send;
      if (clear) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (do_bksp) begin
        count_q <= count_m1;
      end else if (do_send) begin
        count_q <= count_q + 1'b1;
      end else if (set_ovf) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign commit   = commit_q;

endmodule

// File: tb/tb_morse_text_buffer.sv
// Self-checking bench for morse_text_buffer: table-driven presses and reads, a commit
// scoreboard, and hand-written sequences for priority and asynchronous reset.
module tb_morse_text_buffer;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          send;
  logic          bksp;
  logic          clear;
  logic [CW-1:0] letter_num;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic          commit;

  morse_text_buffer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .bksp       (bksp),
    .clear      (clear),
    .letter_num (letter_num),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .commit     (commit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];  // expected count value seen with each commit pulse
  int sb_exp;

  typedef struct {
    logic [CW-1:0] letter;
    int            exp_commit;
    int            exp_count;
  } press_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            exp_data;
  } read_vec_t;

  press_vec_t pvecs[4];
  read_vec_t  rvecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit scoreboard: every pulse must match a queued expectation
  always @(negedge clk) begin
    if (!reset && commit) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got commit with count %0d, expected none", count);
      end else begin
        sb_exp = exp_q.pop_front();
        if (int'(count) != sb_exp) begin
          errors++;
          $display("FAIL sb_commit_count: got %0d, expected %0d", count, sb_exp);
        end
      end
    end
  end

  // Holds the button(s) 10 clk, releases, lets the synchronizer settle
  task automatic press(input logic s, input logic b, input int exp_commit, input int exp_cnt,
                       input string name);
    int seen;
    int pulses;
    seen   = 0;
    pulses = 0;
    if (exp_commit != 0) exp_q.push_back(exp_cnt);
    send = s;
    bksp = b;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (commit) begin
        pulses++;
        if (seen == 0) seen = i;
      end
    end
    send = 1'b0;
    bksp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commit) pulses++;
    end
    check({name, "_pulses"}, pulses, exp_commit);
    if (exp_commit != 0) check({name, "_latency"}, seen, 3);
    check({name, "_count"}, int'(count), exp_cnt);
  endtask

  task automatic read_check(input logic [AW-1:0] addr, input int exp, input string name);
    rd_addr = addr;
    tick();
    check(name, int'(rd_data), exp);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    send       = 1'b0;
    bksp       = 1'b0;
    clear      = 1'b0;
    letter_num = '0;
    rd_addr    = '0;

    pvecs[0] = '{letter: 5'd1,  exp_commit: 1, exp_count: 1};
    pvecs[1] = '{letter: 5'd3,  exp_commit: 1, exp_count: 2};
    pvecs[2] = '{letter: 5'd0,  exp_commit: 0, exp_count: 2};
    pvecs[3] = '{letter: 5'd30, exp_commit: 0, exp_count: 2};
    rvecs[0] = '{addr: 5'd0,  exp_data: 1};
    rvecs[1] = '{addr: 5'd1,  exp_data: 3};
    rvecs[2] = '{addr: 5'd2,  exp_data: 0};
    rvecs[3] = '{addr: 5'd31, exp_data: 0};

    repeat (3) tick();
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_commit", int'(commit), 0);
    check("rst_rd_data", int'(rd_data), 0);
    reset = 1'b0;
    repeat (5) tick();

    // Commit letters and invalid codes
    foreach (pvecs[i]) begin
      letter_num = pvecs[i].letter;
      press(1'b1, 1'b0, pvecs[i].exp_commit, pvecs[i].exp_count, "press_tbl");
    end
    foreach (rvecs[i]) read_check(rvecs[i].addr, rvecs[i].exp_data, "read_tbl");

    // Fill and overflow
    do_clear();
    check("clr1_count", int'(count), 0);
    letter_num = 5'd27;
    for (int i = 0; i < DEPTH; i++) press(1'b1, 1'b0, 1, i + 1, "fill");
    check("fill_full", int'(full), 1);
    check("fill_no_ovf", int'(overflow), 0);
    press(1'b1, 1'b0, 0, DEPTH, "ovf_press");
    check("ovf_flag", int'(overflow), 1);
    read_check(5'd31, 27, "fill_last_cell");
    do_clear();
    check("clr_count", int'(count), 0);
    check("clr_full", int'(full), 0);
    check("clr_overflow", int'(overflow), 0);
    for (int a = 0; a < DEPTH; a++) read_check(AW'(a), 0, "clr_read");

    // Backspace
    letter_num = 5'd5; press(1'b1, 1'b0, 1, 1, "bk_store");
    letter_num = 5'd6; press(1'b1, 1'b0, 1, 2, "bk_store");
    letter_num = 5'd7; press(1'b1, 1'b0, 1, 3, "bk_store");
    press(1'b0, 1'b1, 0, 2, "bk1");
    read_check(5'd2, 0, "bk_cell2");
    read_check(5'd1, 6, "bk_cell1");
    press(1'b0, 1'b1, 0, 1, "bk2");
    press(1'b0, 1'b1, 0, 0, "bk3");
    press(1'b0, 1'b1, 0, 0, "bk_underflow");
    read_check(5'd0, 0, "bk_cell0");

    // Same-cycle send and backspace requests: backspace wins
    letter_num = 5'd9; press(1'b1, 1'b0, 1, 1, "sim_store");
    press(1'b1, 1'b1, 0, 0, "sim_both");

    // Clear in the cycle the send request is live
    press(1'b1, 1'b0, 1, 1, "clrsend_store");
    send = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrsend_commit", int'(commit), 0);
    check("clrsend_count", int'(count), 0);
    repeat (8) tick();
    send = 1'b0;
    repeat (4) tick();
    check("clrsend_count_after", int'(count), 0);

    // Asynchronous reset while send is held
    letter_num = 5'd12;
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1, i + 1, "ar_store");
    rd_addr = 5'd0;
    tick();
    check("ar_pre_rd", int'(rd_data), 12);
    send = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", int'(count), 0);
    check("ar_rd_data", int'(rd_data), 0);
    check("ar_full", int'(full), 0);
    check("ar_overflow", int'(overflow), 0);
    check("ar_commit", int'(commit), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) tick();
    check("ar_held_count", int'(count), 0);
    send = 1'b0;
    repeat (4) tick();
    press(1'b1, 1'b0, 1, 1, "ar_repress");

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the run can never hang
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
